seg_scan_decoder: RTL

Reads the multiplexed four-digit seven-segment bus that `top` drives (`seg`, `digit`), reassembles each scanned frame and decodes it into a status code (ON, OFF, ERR, OPEN, blank). It is the receive end of the display interface. We use it in-fabric for self-check and as the source for status-mirroring logic. A status is reported only after two identical consecutive frames, so a half-updated scan never surfaces.

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/seg_glyph_decode.sv | 22 ++
 rtl/seg_scan_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph, segment-pattern and status definitions for the seven-segment link
package seg_pkg;

    typedef logic [3:0] glyph_t;

    typedef enum logic [2:0] {
        ST_NONE  = 3'd0,
        ST_ON    = 3'd1,
        ST_OFF   = 3'd2,
        ST_ERR   = 3'd3,
        ST_OPEN  = 3'd4,
        ST_BLANK = 3'd7
    } status_e;

    localparam glyph_t GLYPH_BLANK = 4'd0;
    localparam glyph_t GLYPH_O     = 4'd1;
    localparam glyph_t GLYPH_N     = 4'd2;
    localparam glyph_t GLYPH_F     = 4'd3;
    localparam glyph_t GLYPH_E     = 4'd4;
    localparam glyph_t GLYPH_R     = 4'd5;
    localparam glyph_t GLYPH_P     = 4'd6;
    localparam glyph_t GLYPH_BAD   = 4'd15;

    // Active-low {g,f,e,d,c,b,a}; dp is carried separately and never decoded.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_P     = 7'h0C;

    function automatic status_e frame_status(input logic [15:0] frame);
        status_e st;
        st = ST_NONE;
        case (frame)
            {GLYPH_O, GLYPH_N, GLYPH_BLANK, GLYPH_BLANK}:     st = ST_ON;
            {GLYPH_O, GLYPH_F, GLYPH_F, GLYPH_BLANK}:         st = ST_OFF;
            {GLYPH_E, GLYPH_R, GLYPH_R, GLYPH_BLANK}:         st = ST_ERR;
            {GLYPH_O, GLYPH_P, GLYPH_E, GLYPH_N}:             st = ST_OPEN;
            {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK}: st = ST_BLANK;
            default:                                          st = ST_NONE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - maps active-low seven-segment patterns to glyph codes
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] glyph
);

    always_comb begin
        case (seg)
            SEG_BLANK: glyph = GLYPH_BLANK;
            SEG_O:     glyph = GLYPH_O;
            SEG_N:     glyph = GLYPH_N;
            SEG_F:     glyph = GLYPH_F;
            SEG_E:     glyph = GLYPH_E;
            SEG_R:     glyph = GLYPH_R;
            SEG_P:     glyph = GLYPH_P;
            default:   glyph = GLYPH_BAD;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - reassembles scanned four-digit frames and reports a debounced status word
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE        = 4,
    parameter int FRAME_TIMEOUT = 2_000_000
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    input  logic [7:0]  seg,
    input  logic [3:0]  digit,
    output logic [2:0]  status,
    output logic        status_valid,
    output logic [15:0] glyph,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);
    localparam logic [SW-1:0] SETTLE_PRE = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TO_MAX     = TW'(FRAME_TIMEOUT);
    localparam logic [TW-1:0] TO_PRE     = TW'(FRAME_TIMEOUT - 1);

    localparam logic [0:0] ACQUIRE = 1'b0;
    localparam logic [0:0] CONFIRM = 1'b1;

    logic [7:0]    seg_q;
    logic [3:0]    digit_q;
    logic [11:0]   in_prev;
    logic [SW-1:0] settle_cnt;
    logic [15:0]   slots;
    logic [3:0]    seen;
    logic [15:0]   prev_frame;
    logic [15:0]   frame_q;
    logic          match_q;
    logic [TW-1:0] to_cnt;
    logic [0:0]    state;
    status_e       status_q;
    status_e       confirm_status;

    logic [3:0]  cur_glyph;
    logic [1:0]  digit_idx;
    logic        digit_ok;
    logic        in_same;
    logic        settle_hit;
    logic        capture;
    logic        frame_done;
    logic        stale_entry;
    logic [3:0]  seen_next;
    logic [15:0] frame_next;

    seg_glyph_decode u_glyph_decode (
        .seg   (seg_q[6:0]),
        .glyph (cur_glyph)
    );

    always_comb begin
        digit_ok  = 1'b1;
        digit_idx = 2'd0;
        case (digit_q)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: digit_ok  = 1'b0;
        endcase
    end

    always_comb begin
        in_same    = ({digit_q, seg_q} == in_prev);
        settle_hit = in_same && (settle_cnt == SETTLE_PRE);
        capture    = settle_hit && digit_ok;
        seen_next  = seen | (4'b0001 << digit_idx);
        // A recapture leaves seen unchanged, so only the last missing digit can complete a frame.
        frame_done = capture && (seen_next == 4'hF);
        frame_next = slots;
        frame_next[{digit_idx, 2'b00} +: 4] = cur_glyph;
        stale_entry    = !frame_done && (to_cnt == TO_PRE);
        confirm_status = frame_status(frame_q);
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            seg_q      <= 8'hFF;
            digit_q    <= 4'hF;
            in_prev    <= 12'hFFF;
            settle_cnt <= '0;
        end else begin
            seg_q   <= seg;
            digit_q <= digit;
            in_prev <= {digit_q, seg_q};
            // Zero is a parked state: an invalid digit pattern stays there until the bus moves.
            if (!in_same)
                settle_cnt <= SW'(1);
            else if (settle_hit && !digit_ok)
                settle_cnt <= '0;
            else if (settle_cnt != '0 && settle_cnt != SETTLE_MAX)
                settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            slots      <= '0;
            seen       <= '0;
            prev_frame <= {4{GLYPH_BAD}};
            frame_q    <= '0;
            match_q    <= 1'b0;
            state      <= ACQUIRE;
        end else begin
            if (capture) begin
                slots <= frame_next;
                seen  <= frame_done ? 4'h0 : seen_next;
            end
            if (frame_done) begin
                frame_q    <= frame_next;
                match_q    <= (frame_next == prev_frame);
                prev_frame <= frame_next;
            end
            state <= (state == ACQUIRE && frame_done) ? CONFIRM : ACQUIRE;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            status_q     <= ST_NONE;
            status_valid <= 1'b0;
            glyph        <= '0;
            to_cnt       <= '0;
        end else begin
            status_valid <= 1'b0;
            if (frame_done)
                to_cnt <= '0;
            else if (!stale)
                to_cnt <= to_cnt + TW'(1);
            if (state == CONFIRM && match_q) begin
                glyph        <= frame_q;
                status_q     <= confirm_status;
                status_valid <= (confirm_status != status_q);
            end else if (stale_entry) begin
                status_q     <= ST_NONE;
                status_valid <= (status_q != ST_NONE);
            end
        end
    end

    assign stale  = (to_cnt == TO_MAX);
    assign status = status_q;

endmodule
